lc3_decode: RTL and testbench
=============================

# lc3_decode

LC-3 decode stage: captures the fetched instruction (`dout`), next PC (`npc_in`) and condition codes (`psr`) when `enable_decode` is high. It registers the instruction and next PC and generates the execute, writeback and memory control words for the downstream execute, writeback and memory-access stages. It sits directly after fetch/instruction memory and is driven by the decode_in agent in the bench. All outputs are registered with one-cycle latency.

## Interface
- Parameters: none. Widths are fixed by the LC-3 ISA.
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `enable_decode` input 1: capture strobe from the controller.
- `dout` input 16: instruction word from instruction memory.
- `npc_in` input 16: PC+1 from fetch.
- `psr` input 3: current condition codes {N,Z,P}.
- `IR` output 16: registered instruction.
- `npc_out` output 16: registered `npc_in`.
- `E_Control` output 6: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_Control` output 2: writeback select.
- `Mem_Control` output 1: 1 = indirect access (LDI/STI).
- `br_taken` output 1: BR condition met.
- `ir_valid` output 1: high for one cycle after each capture.
- `illegal_op` output 1: present only with `DECODE_ILLEGAL_CHECK_EN`.

## Operation
- Capture: on a rising edge with `enable_decode`=1, all outputs load from the decoded `dout`, `npc_in` and `psr`. With `enable_decode`=0, all outputs hold, except `ir_valid`, which goes to 0.
- Back-to-back enables capture a new instruction every cycle. `ir_valid` stays 1 throughout.
- alu_control:
  - ADD(0001) = 00
  - AND(0101) = 01
  - NOT(1001) = 10
  - all other opcodes = 00
- op2select:
  - ADD/AND: `~dout[5]` (1 = register operand, 0 = imm5).
  - All other opcodes: 0.
- pcselect1:
  - 01 (offset9): BR(0000), LD(0010), LDI(1010), ST(0011), STI(1011), LEA(1110).
  - 10 (offset6): LDR(0110), STR(0111).
  - 11 (zero): JMP(1100).
  - 00: all other opcodes.
- pcselect2:
  - 1 (npc base): BR, LD, LDI, ST, STI, LEA.
  - 0: all other opcodes.
- W_Control:
  - 00: ALU ops.
  - 01 (memout): LD, LDR, LDI.
  - 10 (pcout): LEA.
  - 00: all other opcodes.
- Mem_Control: 1 only for LDI and STI.
- br_taken: `|(dout[11:9] & psr)` when opcode = BR; otherwise 0. BR with nzp=000 gives 0.
- Unsupported opcodes (JSR 0100, RTI 1000, RES 1101, TRAP 1111): all control fields decode to 0. `IR` and `npc_out` still capture.

## Timing
- Latency: exactly one clock from the `enable_decode` sample to valid outputs.
- Reset: asynchronous assert (`reset`=0) clears every output to 0 immediately, including `ir_valid` and `illegal_op`. Release is synchronous to the next rising edge. An enable on the release edge is ignored.
- Reset mid-stream: any in-flight capture is lost. Outputs stay 0 until the first enable after release.
- `psr` is sampled on the same edge as `dout`. Later `psr` changes do not alter the registered `br_taken`.
- No combinational path from any input to any output.

## Configuration
- `DECODE_ILLEGAL_CHECK_EN`
  - Defined: the `illegal_op` port exists. It is registered with the same capture rule as the other outputs and is 1 for JSR/RTI/RES/TRAP.
  - Undefined: the port and its logic are absent. Unsupported opcodes decode silently as described in Operation.

## Structure
- Package `lc3_decode_pkg` holds:
  - opcode enum `lc3_opcode_t`
  - typedef `e_control_t` (packed struct matching the `E_Control` bit order)
  - constants for alu_control, pcselect1 and W_Control encodings
- One sub-module: `lc3_decode_ctrl_gen`, purely combinational. It maps `dout` and `psr` to the control fields plus br_taken/illegal.
- The top module holds only the capture registers and the reset logic.

## Test plan
- Reset: drive `reset`=0 mid-run with outputs non-zero. All outputs read 0 in the same cycle, before any clock edge.
- ADD R1,R2,R3: `dout`=16'h1283, `npc_in`=16'h3001, enable=1. Next edge:
  - `IR`=1283, `npc_out`=3001
  - `E_Control`=6'b000001, `W_Control`=00, `Mem_Control`=0, `ir_valid`=1
- LDI: `dout`=16'hA405. Next edge:
  - `E_Control`=6'b000110, `W_Control`=01, `Mem_Control`=1
- Hold: enable=0 while `dout` changes to 16'h5020 for three cycles. `IR` stays at its prior value and `ir_valid`=0.
- BR: `dout`=16'h0A02 (nzp=101).
  - `psr`=001 gives `br_taken`=1 and `E_Control`=6'b000110.
  - `psr`=010 gives `br_taken`=0.
- Illegal (macro defined): `dout`=16'hF025 gives `illegal_op`=1 and `E_Control`=0. The next ADD capture clears `illegal_op`.

Source files
------------

// File: rtl/lc3_decode_pkg.sv
// lc3_decode_pkg: opcodes, the execute control word layout and the control field encodings for the LC-3 decode stage
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3_opcode_t;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_ZERO = 2'b11;

  localparam logic PC2_NPC = 1'b1;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_MEM = 2'b01;
  localparam logic [1:0] W_PC  = 2'b10;

  function automatic logic is_unsupported(input lc3_opcode_t op);
    return op inside {OP_JSR, OP_RTI, OP_RES, OP_TRAP};
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl_gen.sv
// lc3_decode_ctrl_gen: combinational opcode decoder producing execute/writeback/memory controls and branch resolution
// Optional DECODE_ILLEGAL_CHECK_EN adds the illegal output flagging JSR/RTI/RES/TRAP.
module lc3_decode_ctrl_gen
  import lc3_decode_pkg::*;
(
  input  logic [3:0] instr_op,
  input  logic [2:0] instr_nzp,
  input  logic       instr_imm,
  input  logic [2:0] psr,
  output e_control_t e_ctrl,
  output logic [1:0] w_ctrl,
  output logic       mem_ctrl,
  output logic       br
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,
  output logic       illegal
`endif
);

  lc3_opcode_t op;

  assign op = lc3_opcode_t'(instr_op);

`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal = is_unsupported(op);
`endif

  // Per-opcode control word; anything not listed (including unsupported opcodes) stays all-zero.
  always_comb begin
    e_ctrl   = '0;
    w_ctrl   = W_ALU;
    mem_ctrl = 1'b0;
    br       = 1'b0;
    case (op)
      OP_ADD: begin
        e_ctrl.alu_control = ALU_ADD;
        e_ctrl.op2select   = ~instr_imm;
      end
      OP_AND: begin
        e_ctrl.alu_control = ALU_AND;
        e_ctrl.op2select   = ~instr_imm;
      end
      OP_NOT: e_ctrl.alu_control = ALU_NOT;
      OP_BR: begin
        e_ctrl.pcselect1 = PC1_OFF9;
        e_ctrl.pcselect2 = PC2_NPC;
        br               = |(instr_nzp & psr);
      end
      OP_LD: begin
        e_ctrl.pcselect1 = PC1_OFF9;
        e_ctrl.pcselect2 = PC2_NPC;
        w_ctrl           = W_MEM;
      end
      OP_LDI: begin
        e_ctrl.pcselect1 = PC1_OFF9;
        e_ctrl.pcselect2 = PC2_NPC;
        w_ctrl           = W_MEM;
        mem_ctrl         = 1'b1;
      end
      OP_ST: begin
        e_ctrl.pcselect1 = PC1_OFF9;
        e_ctrl.pcselect2 = PC2_NPC;
      end
      OP_STI: begin
        e_ctrl.pcselect1 = PC1_OFF9;
        e_ctrl.pcselect2 = PC2_NPC;
        mem_ctrl         = 1'b1;
      end
      OP_LEA: begin
        e_ctrl.pcselect1 = PC1_OFF9;
        e_ctrl.pcselect2 = PC2_NPC;
        w_ctrl           = W_PC;
      end
      OP_LDR: begin
        e_ctrl.pcselect1 = PC1_OFF6;
        w_ctrl           = W_MEM;
      end
      OP_STR: e_ctrl.pcselect1 = PC1_OFF6;
      OP_JMP: e_ctrl.pcselect1 = PC1_ZERO;
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage registering the instruction, next PC and decoded control words
// Optional DECODE_ILLEGAL_CHECK_EN adds the registered illegal_op output.
module lc3_decode
  import lc3_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  input  logic [2:0]  psr,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        br_taken,
  output logic        ir_valid
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,
  output logic        illegal_op
`endif
);

  e_control_t e_ctrl;
  logic [1:0] w_ctrl;
  logic       mem_ctrl;
  logic       br;

  logic [15:0] ir_q, ir_d;
  logic [15:0] npc_q, npc_d;
  e_control_t  e_q, e_d;
  logic [1:0]  w_q, w_d;
  logic        mem_q, mem_d;
  logic        br_q, br_d;
  logic        valid_q, valid_d;

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic illegal;
  logic ill_q, ill_d;
`endif

  lc3_decode_ctrl_gen u_ctrl_gen (
    .instr_op  (dout[15:12]),
    .instr_nzp (dout[11:9]),
    .instr_imm (dout[5]),
    .psr       (psr),
    .e_ctrl    (e_ctrl),
    .w_ctrl    (w_ctrl),
    .mem_ctrl  (mem_ctrl),
    .br        (br)
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    .illegal   (illegal)
`endif
  );

  // Load everything on a capture; otherwise hold, except ir_valid which only marks the cycle after a capture.
  always_comb begin
    ir_d    = enable_decode ? dout     : ir_q;
    npc_d   = enable_decode ? npc_in   : npc_q;
    e_d     = enable_decode ? e_ctrl   : e_q;
    w_d     = enable_decode ? w_ctrl   : w_q;
    mem_d   = enable_decode ? mem_ctrl : mem_q;
    br_d    = enable_decode ? br       : br_q;
    valid_d = enable_decode;
`ifdef DECODE_ILLEGAL_CHECK_EN
    ill_d   = enable_decode ? illegal  : ill_q;
`endif
  end

  // Capture registers with asynchronous clear; a capture in flight when reset asserts is discarded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q    <= '0;
      npc_q   <= '0;
      e_q     <= '0;
      w_q     <= '0;
      mem_q   <= 1'b0;
      br_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      e_q     <= e_d;
      w_q     <= w_d;
      mem_q   <= mem_d;
      br_q    <= br_d;
      valid_q <= valid_d;
`ifdef DECODE_ILLEGAL_CHECK_EN
      ill_q   <= ill_d;
`endif
    end
  end

  assign IR          = ir_q;
  assign npc_out     = npc_q;
  assign E_Control   = e_q;
  assign W_Control   = w_q;
  assign Mem_Control = mem_q;
  assign br_taken    = br_q;
  assign ir_valid    = valid_q;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal_op  = ill_q;
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: scoreboard bench for lc3_decode; also exercises illegal_op when DECODE_ILLEGAL_CHECK_EN is defined
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [2:0]  psr;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        br_taken;
  logic        ir_valid;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        illegal_op;
`endif

  int errors = 0;
  int checks = 0;

  logic [42:0] exp_q[$];
  logic [42:0] held = '0;

  lc3_decode dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .psr           (psr),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .br_taken      (br_taken),
    .ir_valid      (ir_valid)
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  always #5 clock = ~clock;

  // Reference: {IR, npc, alu, pcsel1, pcsel2, op2sel, W, Mem, br, illegal}
  function automatic logic [42:0] model(input logic [15:0] d, input logic [15:0] n, input logic [2:0] p);
    int op;
    logic [1:0] alu, pc1, w;
    logic pc2, op2, mem, br, ill;
    op  = int'(d[15:12]);
    alu = (op == 5) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
    op2 = (op == 1 || op == 5) ? ~d[5] : 1'b0;
    pc2 = op inside {0, 2, 3, 10, 11, 14};
    pc1 = pc2 ? 2'd1 : (op inside {6, 7}) ? 2'd2 : (op == 12) ? 2'd3 : 2'd0;
    w   = (op inside {2, 6, 10}) ? 2'd1 : (op == 14) ? 2'd2 : 2'd0;
    mem = op inside {10, 11};
    br  = (op == 0) && ((d[11:9] & p) != 3'b000);
`ifdef DECODE_ILLEGAL_CHECK_EN
    ill = op inside {4, 8, 13, 15};
`else
    ill = 1'b0;
`endif
    return {d, n, alu, pc1, pc2, op2, w, mem, br, ill};
  endfunction

  function automatic logic [43:0] snap();
    logic ill;
`ifdef DECODE_ILLEGAL_CHECK_EN
    ill = illegal_op;
`else
    ill = 1'b0;
`endif
    return {IR, npc_out, E_Control, W_Control, Mem_Control, br_taken, ill, ir_valid};
  endfunction

  task automatic chk(input string name, input logic [43:0] got, input logic [43:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] d, input logic [15:0] n, input logic [2:0] p);
    @(negedge clock);
    enable_decode = en;
    dout          = d;
    npc_in        = n;
    psr           = p;
    if (en && reset) exp_q.push_back(model(d, n, p));
  endtask

  // Monitor: pops one expectation per ir_valid pulse, otherwise outputs must hold.
  always @(negedge clock) begin
    if (!reset) chk("in_reset", snap(), '0);
    else if (ir_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got IR %h expected no capture", IR);
      end else begin
        held = exp_q.pop_front();
        chk("capture", snap(), {held, 1'b1});
      end
    end else chk("hold", snap(), {held, 1'b0});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    enable_decode = 1'b0;
    dout = '0;
    npc_in = '0;
    psr = '0;
    #1 reset = 1'b0;
    #1 chk("reset_init", snap(), '0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 16'h1283, 16'h3001, 3'b000);
    drive(1'b1, 16'hA405, 16'h3002, 3'b010);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h5020, 16'h3003, 3'($urandom));
    drive(1'b1, 16'h0A02, 16'h3004, 3'b001);
    drive(1'b1, 16'h0A02, 16'h3005, 3'b010);
    drive(1'b1, 16'hF025, 16'h3006, 3'b111);
    drive(1'b1, 16'h1283, 16'h3007, 3'b000);
    drive(1'b1, 16'h0000, 16'h3008, 3'b111);
    drive(1'b1, 16'h0A02, 16'h3009, 3'b100);
    drive(1'b0, 16'h0A02, 16'h3009, 3'b111);
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 3'($urandom));
    drive(1'b1, 16'h1283, 16'h300A, 3'b000);
    drive(1'b1, 16'h5020, 16'h300B, 3'b000);
    #2 reset = 1'b0;
    #1 chk("reset_async", snap(), '0);
    exp_q.delete();
    held = '0;
    for (int i = 0; i < 2; i++) drive(1'b1, 16'($urandom), 16'($urandom), 3'($urandom));
    @(negedge clock);
    reset = 1'b1;
    enable_decode = 1'b0;
    drive(1'b0, 16'h1283, 16'h300C, 3'b000);
    for (int i = 0; i < 100; i++)
      drive($urandom_range(0, 1) != 0, 16'($urandom), 16'($urandom), 3'($urandom));
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    chk("drain", 44'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
